code_stim_gen: RTL

Programmable 3-bit code sequence generator. It is the driving end of the code/decode path: it produces the incrementing `a` codes that the downstream shift-and-decode logic consumes (symbol = `a >> 1`). It presents each code on a valid/ready handshake and tracks which of the four decoded symbols were actually delivered, so the bench can flag an unreachable or missing case branch. It sits between the test controller (`start`/`done`) and the decoder under test.

---
 rtl/code_stim_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/code_stim_gen.sv
// Emits COUNT incrementing 3-bit codes from START over valid/ready, tracking decoded-symbol coverage.
// Latency: first code offered DELAY cycles after start; GAP idle cycles after each accepted code.
module code_stim_gen #(
  parameter logic [2:0] START = 3'd1,
  parameter int         COUNT = 8,
  parameter int         DELAY = 2,
  parameter int         GAP   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic [2:0]                     a_out,
  output logic                           a_valid,
  input  logic                           a_ready,
  output logic [1:0]                     sym_out,
  output logic [3:0]                     sym_hit,
  output logic [$clog2(COUNT+1)-1:0]     issued,
  output logic                           done
);

  localparam int IW   = $clog2(COUNT + 1);
  localparam int CMAX = (DELAY > GAP) ? DELAY : GAP;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  typedef enum logic [2:0] {IDLE, DLY, ISSUE, WAIT, FIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign sym_out = a_out[2:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_out   <= '0;
      a_valid <= 1'b0;
      busy    <= 1'b0;
      sym_hit <= '0;
      issued  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_out   <= START;
            sym_hit <= '0;
            issued  <= '0;
            busy    <= 1'b1;
            if (DELAY == 0) begin
              state   <= ISSUE;
              a_valid <= 1'b1;
            end else begin
              state <= DLY;
              cnt   <= CW'(DELAY - 1);
            end
          end
        end
        DLY, WAIT: begin
          if (cnt == '0) begin
            state   <= ISSUE;
            a_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ISSUE: begin
          // a_out is frozen until the decoder takes it, however long that is
          if (a_ready) begin
            sym_hit <= sym_hit | (4'b0001 << a_out[2:1]);
            issued  <= issued + IW'(1);
            if (issued == IW'(COUNT - 1)) begin
              state   <= FIN;
              a_valid <= 1'b0;
              done    <= 1'b1;
            end else begin
              a_out <= a_out + 3'd1;
              if (GAP != 0) begin
                state   <= WAIT;
                a_valid <= 1'b0;
                cnt     <= CW'(GAP - 1);
              end
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
